// File: rtl/serial_add_arb.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_arb
// Brief    : Two-requester round-robin front end sharing one bit-serial
//            full-adder slice; returns sum/carry/id over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_arb #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_id
);

    localparam int            CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             id_q, id_d;
    logic             last_q, last_d;

    logic             w_grant0;
    logic             w_grant1;
    logic             w_sbit;
    logic             w_cnext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

    // Round-robin: on a tie, the requester that did not win last time goes.
    assign w_grant0 = req0_valid && (!req1_valid || last_q);
    assign w_grant1 = req1_valid && (!req0_valid || !last_q);

    assign w_sbit  = a_q[0] ^ b_q[0] ^ carry_q;
    assign w_cnext = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        sum_d      = sum_q;
        carry_d    = carry_q;
        cout_d     = cout_q;
        id_d       = id_q;
        last_d     = last_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Ready is gated by rst so it reads 0 the instant reset asserts.
                req0_ready = w_grant0 && !rst;
                req1_ready = w_grant1 && !rst;
                if (w_grant0 || w_grant1) begin
                    a_d     = w_grant1 ? req1_a   : req0_a;
                    b_d     = w_grant1 ? req1_b   : req0_b;
                    carry_d = w_grant1 ? req1_cin : req0_cin;
                    id_d    = w_grant1;
                    last_d  = w_grant1;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                carry_d = w_cnext;
                acc_d   = {w_sbit, acc_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                // Result register is separate so res_sum holds through SHIFT.
                if (cnt_q == C_LAST) begin
                    sum_d   = {w_sbit, acc_q[WIDTH-1:1]};
                    cout_d  = w_cnext;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign res_valid = (state_q == S_DONE);
    assign res_sum   = sum_q;
    assign res_cout  = cout_q;
    assign res_id    = id_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_arb
// Brief    : Directed and random checks of serial_add_arb at WIDTH 8 and 16
//            against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_add_arb;

    logic        clk = 1'b0;
    logic        rst8, rst16;
    logic        v0, v1, c0, c1, res_ready;
    logic [31:0] a0, b0, a1, b1;

    logic        d8_r0, d8_r1, d8_rv, d8_cout, d8_id;
    logic [7:0]  d8_sum;
    logic        d16_r0, d16_r1, d16_rv, d16_cout, d16_id;
    logic [15:0] d16_sum;

    always #5 clk = ~clk;

    serial_add_arb #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst8),
        .req0_valid(v0), .req0_ready(d8_r0), .req0_a(a0[7:0]), .req0_b(b0[7:0]), .req0_cin(c0),
        .req1_valid(v1), .req1_ready(d8_r1), .req1_a(a1[7:0]), .req1_b(b1[7:0]), .req1_cin(c1),
        .res_valid(d8_rv), .res_ready(res_ready), .res_sum(d8_sum), .res_cout(d8_cout), .res_id(d8_id)
    );

    serial_add_arb #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst16),
        .req0_valid(v0), .req0_ready(d16_r0), .req0_a(a0[15:0]), .req0_b(b0[15:0]), .req0_cin(c0),
        .req1_valid(v1), .req1_ready(d16_r1), .req1_a(a1[15:0]), .req1_b(b1[15:0]), .req1_cin(c1),
        .res_valid(d16_rv), .res_ready(res_ready), .res_sum(d16_sum), .res_cout(d16_cout), .res_id(d16_id)
    );

    // Active instance selector and observed outputs
    logic        sel;
    logic        o_r0, o_r1, o_rv, o_cout, o_id;
    logic [31:0] o_sum;

    int ncmp = 0;
    int nfail = 0;

    // Transaction-level reference state
    logic        busy, last;
    int          hs, cyc, e_id, nacc;
    logic [63:0] e_val;
    int          acc_cyc[$];
    int          acc_id[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        o_r0   = sel ? d16_r0   : d8_r0;
        o_r1   = sel ? d16_r1   : d8_r1;
        o_rv   = sel ? d16_rv   : d8_rv;
        o_cout = sel ? d16_cout : d8_cout;
        o_id   = sel ? d16_id   : d8_id;
        o_sum  = sel ? {16'b0, d16_sum} : {24'b0, d8_sum};
    endtask

    task automatic model_reset();
        busy = 1'b0;
        last = 1'b1;
        acc_cyc.delete();
        acc_id.delete();
    endtask

    // One clock: sample before the edge, check against the model, advance it.
    task automatic tick();
        logic        idle, g0, g1, erv;
        int          w;
        logic [63:0] m;
        #1;
        sample();
        w    = sel ? 16 : 8;
        m    = (64'd1 << w) - 64'd1;
        idle = !busy;
        g0   = idle && v0 && (!v1 || last);
        g1   = idle && v1 && (!v0 || !last);
        erv  = busy && (cyc >= hs + w + 1);
        chk("req0_ready", {63'b0, o_r0}, {63'b0, g0});
        chk("req1_ready", {63'b0, o_r1}, {63'b0, g1});
        chk("res_valid", {63'b0, o_rv}, {63'b0, erv});
        if (erv) begin
            chk("res_sum", {32'b0, o_sum}, e_val & m);
            chk("res_cout", {63'b0, o_cout}, (e_val >> w) & 64'd1);
            chk("res_id", {63'b0, o_id}, 64'(e_id));
            if (res_ready) busy = 1'b0;
        end
        if (g0 || g1) begin
            busy  = 1'b1;
            hs    = cyc;
            e_id  = g1 ? 1 : 0;
            last  = g1;
            nacc++;
            e_val = g1 ? ((64'(a1) & m) + (64'(b1) & m) + 64'(c1))
                       : ((64'(a0) & m) + (64'(b0) & m) + 64'(c0));
        end
        if (o_r0 || o_r1) begin
            acc_cyc.push_back(cyc);
            acc_id.push_back(o_r1 ? 1 : 0);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic wait_result(output int n);
        n = 61;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (o_rv) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        sample();
        chk({tag, "_valid"}, {63'b0, o_rv}, 64'd0);
        chk({tag, "_sum"}, {32'b0, o_sum}, 64'd0);
        chk({tag, "_cout"}, {63'b0, o_cout}, 64'd0);
        chk({tag, "_id"}, {63'b0, o_id}, 64'd0);
        chk({tag, "_rdy0"}, {63'b0, o_r0}, 64'd0);
        chk({tag, "_rdy1"}, {63'b0, o_r1}, 64'd0);
    endtask

    task automatic reset_dut();
        v0 = 1'b0;
        v1 = 1'b0;
        if (sel) rst16 = 1'b1; else rst8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs("rst");
        if (sel) rst16 = 1'b0; else rst8 = 1'b0;
        model_reset();
    endtask

    task automatic drain();
        v0 = 1'b0;
        v1 = 1'b0;
        res_ready = 1'b1;
        repeat (20) tick();
    endtask

    initial begin
        int n;
        logic [31:0] held;
        sel = 1'b0; rst8 = 1'b1; rst16 = 1'b1;
        v0 = 1'b1; v1 = 1'b1; c0 = 1'b0; c1 = 1'b0; res_ready = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        cyc = 0; nacc = 0; hs = 0; e_id = 0; e_val = '0;
        model_reset();
        #3;
        check_reset_outputs("por");
        @(negedge clk);
        reset_dut();

        // Single request: FF + 01
        res_ready = 1'b1;
        v0 = 1'b1; a0 = 32'hFF; b0 = 32'h01; c0 = 1'b0;
        tick();
        chk("t1_grant", {63'b0, o_r0}, 64'd1);
        v0 = 1'b0;
        wait_result(n);
        chk("t1_latency", 64'(n), 64'd9);
        chk("t1_sum", {32'b0, o_sum}, 64'h00);
        chk("t1_cout", {63'b0, o_cout}, 64'd1);
        chk("t1_id", {63'b0, o_id}, 64'd0);

        // 7F + 80 + 1 on req0, then 12 + 34 on req1
        v0 = 1'b1; a0 = 32'h7F; b0 = 32'h80; c0 = 1'b1;
        tick();
        v0 = 1'b0;
        wait_result(n);
        chk("t2_sum", {32'b0, o_sum}, 64'h00);
        chk("t2_cout", {63'b0, o_cout}, 64'd1);
        v1 = 1'b1; a1 = 32'h12; b1 = 32'h34; c1 = 1'b0;
        tick();
        chk("t3_grant", {63'b0, o_r1}, 64'd1);
        v1 = 1'b0;
        wait_result(n);
        chk("t3_sum", {32'b0, o_sum}, 64'h46);
        chk("t3_cout", {63'b0, o_cout}, 64'd0);
        chk("t3_id", {63'b0, o_id}, 64'd1);

        // Both valid continuously after reset
        reset_dut();
        res_ready = 1'b1;
        v0 = 1'b1; a0 = 32'h01; b0 = 32'h02; c0 = 1'b0;
        v1 = 1'b1; a1 = 32'h10; b1 = 32'h20; c1 = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (acc_id.size() >= 4) break;
            tick();
        end
        chk("rr_count", 64'(acc_id.size() >= 4), 64'd1);
        if (acc_id.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("rr_order", 64'(acc_id[i]), 64'(i % 2));
            for (int i = 1; i < 4; i++) chk("rr_spacing", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd10);
        end
        drain();

        // Backpressure
        res_ready = 1'b0;
        v0 = 1'b1; a0 = 32'h3C; b0 = 32'h41; c0 = 1'b0;
        tick();
        v0 = 1'b0;
        wait_result(n);
        held = o_sum;
        chk("bp_first", {32'b0, held}, 64'h7D);
        v0 = 1'b1; v1 = 1'b1; a1 = 32'h11; b1 = 32'h22; c1 = 1'b0;
        repeat (5) begin
            tick();
            chk("bp_valid", {63'b0, o_rv}, 64'd1);
            chk("bp_hold", {32'b0, o_sum}, {32'b0, held});
            chk("bp_noready", {62'b0, o_r0, o_r1}, 64'd0);
        end
        res_ready = 1'b1;
        tick();
        tick();
        chk("bp_drop", {63'b0, o_rv}, 64'd0);
        chk("bp_regrant", {63'b0, o_r1}, 64'd1);
        drain();

        // Reset in the middle of SHIFT (counter = 3)
        v0 = 1'b1; a0 = 32'hA5; b0 = 32'h5A; c0 = 1'b1;
        tick();
        v0 = 1'b0;
        repeat (3) tick();
        v0 = 1'b1; v1 = 1'b1;
        #2 rst8 = 1'b1;
        #1;
        check_reset_outputs("async");
        @(posedge clk);
        @(negedge clk);
        rst8 = 1'b0;
        model_reset();
        v0 = 1'b0; v1 = 1'b0;
        repeat (12) tick();
        v0 = 1'b1; v1 = 1'b1;
        tick();
        chk("tie_after_rst", {62'b0, o_r0, o_r1}, 64'd2);
        v0 = 1'b0; v1 = 1'b0;
        wait_result(n);
        chk("tie_after_rst_id", {63'b0, o_id}, 64'd0);
        drain();

        // Random traffic, WIDTH 8 then WIDTH 16
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            rst8 = 1'b1;
            reset_dut();
            nacc = 0;
            for (int i = 0; i < 40000; i++) begin
                if (nacc >= 500) break;
                v0 = ($urandom_range(0, 9) < 7);
                v1 = ($urandom_range(0, 9) < 7);
                a0 = $urandom; b0 = $urandom; c0 = $urandom_range(0, 1) == 1;
                a1 = $urandom; b1 = $urandom; c1 = $urandom_range(0, 1) == 1;
                res_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
            chk("rand_ops", 64'(nacc >= 500), 64'd1);
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
`default_nettype wire
